// File: rtl/shift_deserializer_if.sv
// Bundle between a serial link, the deserializer and its parallel consumer.
// Inputs are driven by the master side; outputs are driven by the slave side.
interface shift_deserializer_if #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2
);

  logic             sync_clr;
  logic             dir;
  logic             bit_in;
  logic             bit_valid;
  logic [WIDTH-1:0] word_out;
  logic             word_valid;
  logic             word_ready;
  logic [CNT_W-1:0] bit_count;
  logic             overrun;

  modport master (
    output sync_clr,
    output dir,
    output bit_in,
    output bit_valid,
    output word_ready,
    input  word_out,
    input  word_valid,
    input  bit_count,
    input  overrun
  );

  modport slave (
    input  sync_clr,
    input  dir,
    input  bit_in,
    input  bit_valid,
    input  word_ready,
    output word_out,
    output word_valid,
    output bit_count,
    output overrun
  );

endinterface

// File: rtl/shift_deserializer.sv
// Serial-to-parallel receiver: collects WIDTH bits (LSB- or MSB-first)
// into a word held in a one-entry valid/ready output buffer.
module shift_deserializer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2
) (
  input  logic                clk,
  input  logic                rst,
  shift_deserializer_if.slave bus
);

  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_lat_q, dir_lat_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             valid_q, valid_d;
  logic             ovr_q, ovr_d;

  logic             accept;
  logic             first;
  logic             ord;
  logic             last;
  logic             complete;
  logic             consume;
  logic [WIDTH-1:0] shifted;

  assign accept   = bus.bit_valid & ~bus.sync_clr;
  assign first    = (cnt_q == '0);
  // Order is latched with the first bit so mid-word dir changes are ignored.
  assign ord      = first ? bus.dir : dir_lat_q;
  assign last     = (cnt_q == LAST);
  assign complete = accept & last;
  assign consume  = valid_q & bus.word_ready;

  always_comb begin
    shifted = '0;
    if (ord) begin
      shifted = {shreg_q[WIDTH-2:0], bus.bit_in};
    end else begin
      shifted = {bus.bit_in, shreg_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    dir_lat_d = dir_lat_q;
    if (bus.sync_clr) begin
      shreg_d = '0;
      cnt_d   = '0;
    end else if (accept) begin
      shreg_d = shifted;
      if (first) begin
        dir_lat_d = bus.dir;
      end
      if (last) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_comb begin
    word_d  = word_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;
    if (complete) begin
      // Consume and refill on the same edge keeps streaming lossless.
      if (!valid_q || bus.word_ready) begin
        word_d  = shifted;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (consume) begin
      valid_d = 1'b0;
    end
    if (bus.sync_clr) begin
      ovr_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      shreg_q   <= '0;
      cnt_q     <= '0;
      dir_lat_q <= 1'b0;
      word_q    <= '0;
      valid_q   <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      dir_lat_q <= dir_lat_d;
      word_q    <= word_d;
      valid_q   <= valid_d;
      ovr_q     <= ovr_d;
    end
  end

  assign bus.word_out   = word_q;
  assign bus.word_valid = valid_q;
  assign bus.bit_count  = cnt_q;
  assign bus.overrun    = ovr_q;

endmodule

// File: tb/tb_shift_deserializer.sv
// Bench for shift_deserializer: directed steps then random traffic,
// every cycle compared with a queue-based word-assembly model.
module tb_shift_deserializer;

  localparam int W  = 4;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  shift_deserializer_if #(.WIDTH(W), .CNT_W(CW)) bus ();

  shift_deserializer #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  int n_assert = 0;
  int n_fail   = 0;

  bit     q_bits[$];
  bit     m_ord;
  int     m_word;
  bit     m_valid;
  bit     m_ovr;

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int assemble(input bit o);
    int w;
    w = 0;
    for (int i = 0; i < W; i++) begin
      if (q_bits[i]) begin
        w = w + (o ? (1 << (W - 1 - i)) : (1 << i));
      end
    end
    return w;
  endfunction

  task automatic model(input bit r, input bit sc, input bit d,
                       input bit b, input bit bv, input bit wr);
    bit done;
    int w;
    done = 1'b0;
    w    = 0;
    if (r) begin
      q_bits.delete();
      m_ord   = 1'b0;
      m_word  = 0;
      m_valid = 1'b0;
      m_ovr   = 1'b0;
      return;
    end
    if (sc) begin
      q_bits.delete();
      m_ovr = 1'b0;
    end else if (bv) begin
      if (q_bits.size() == 0) m_ord = d;
      q_bits.push_back(b);
      if (q_bits.size() == W) begin
        w    = assemble(m_ord);
        done = 1'b1;
        q_bits.delete();
      end
    end
    if (done) begin
      if (!m_valid || wr) begin
        m_word  = w;
        m_valid = 1'b1;
      end else begin
        m_ovr = 1'b1;
      end
    end else if (m_valid && wr) begin
      m_valid = 1'b0;
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".word_out"},   int'(bus.word_out),   m_word);
    chk({tag, ".word_valid"}, int'(bus.word_valid), int'(m_valid));
    chk({tag, ".bit_count"},  int'(bus.bit_count),  q_bits.size());
    chk({tag, ".overrun"},    int'(bus.overrun),    int'(m_ovr));
  endtask

  task automatic step(input string tag, input bit r, input bit sc,
                      input bit d, input bit b, input bit bv,
                      input bit wr);
    @(negedge clk);
    rst            = r;
    bus.sync_clr   = sc;
    bus.dir        = d;
    bus.bit_in     = b;
    bus.bit_valid  = bv;
    bus.word_ready = wr;
    @(posedge clk);
    model(r, sc, d, b, bv, wr);
    #1;
    check_all(tag);
  endtask

  task automatic send_word(input string tag, input bit d,
                           input logic [3:0] bits, input bit wr);
    logic [3:0] v;
    v = bits;
    for (int i = 3; i >= 0; i--) begin
      step(tag, 1'b0, 1'b0, d, v[i], 1'b1, wr);
    end
  endtask

  initial begin
    rst            = 1'b1;
    bus.sync_clr   = 1'b0;
    bus.dir        = 1'b0;
    bus.bit_in     = 1'b0;
    bus.bit_valid  = 1'b0;
    bus.word_ready = 1'b0;

    step("rst", 1, 0, 0, 0, 0, 0);
    step("rst", 1, 0, 0, 0, 0, 0);
    chk("rst_word",  int'(bus.word_out),   0);
    chk("rst_valid", int'(bus.word_valid), 0);
    chk("rst_cnt",   int'(bus.bit_count),  0);
    chk("rst_ovr",   int'(bus.overrun),    0);

    // LSB-first, bits 1,0,1,1 in send order
    send_word("lsb", 0, 4'b1011, 1);
    chk("lsb_word",  int'(bus.word_out),   4'b1101);
    chk("lsb_valid", int'(bus.word_valid), 1);
    step("lsb_drop", 0, 0, 0, 0, 0, 1);
    chk("lsb_pulse", int'(bus.word_valid), 0);

    // MSB-first, bits 0,1,1,1 with 2-cycle gaps
    begin
      logic [3:0] v;
      v = 4'b0111;
      for (int i = 3; i >= 0; i--) begin
        step("msb", 0, 0, 1, v[i], 1, 1);
        if (i != 0) begin
          step("msb_gap", 0, 0, 0, 0, 0, 1);
          step("msb_gap", 0, 0, 0, 1, 0, 1);
        end
      end
    end
    chk("msb_word", int'(bus.word_out), 4'b0111);

    // dir=1 on first bit only, bits 0,0,1,0
    step("flip", 0, 0, 1, 0, 1, 1);
    step("flip", 0, 0, 0, 0, 1, 1);
    step("flip", 0, 0, 0, 1, 1, 1);
    step("flip", 0, 0, 0, 0, 1, 1);
    chk("flip_word", int'(bus.word_out), 4'b0010);
    step("flip_idle", 0, 0, 0, 0, 0, 1);

    // Backpressure and overrun
    send_word("bp", 1, 4'b0111, 0);
    send_word("bp", 1, 4'b0010, 0);
    chk("bp_word", int'(bus.word_out), 4'b0111);
    chk("bp_ovr",  int'(bus.overrun),  1);
    step("bp_rdy", 0, 0, 0, 0, 0, 1);
    chk("bp_valid", int'(bus.word_valid), 0);
    chk("bp_ovr2",  int'(bus.overrun),    1);
    step("bp_clr", 0, 1, 0, 0, 0, 0);
    chk("bp_ovr3",  int'(bus.overrun),    0);

    // Completion and consume on the same edge
    send_word("sim", 1, 4'b0111, 0);
    step("sim", 0, 0, 1, 1, 1, 0);
    step("sim", 0, 0, 1, 0, 1, 0);
    step("sim", 0, 0, 1, 1, 1, 0);
    step("sim", 0, 0, 1, 0, 1, 1);
    chk("sim_word",  int'(bus.word_out),   4'b1010);
    chk("sim_valid", int'(bus.word_valid), 1);
    chk("sim_ovr",   int'(bus.overrun),    0);
    step("sim_idle", 0, 0, 0, 0, 0, 1);

    // Abort with a bit in the same cycle
    step("abort", 0, 0, 0, 1, 1, 1);
    step("abort", 0, 0, 0, 1, 1, 1);
    step("abort_clr", 0, 1, 0, 1, 1, 1);
    chk("abort_cnt", int'(bus.bit_count), 0);
    send_word("abort_w", 0, 4'b0110, 1);
    chk("abort_word", int'(bus.word_out), 4'b0110);

    // Reset mid-word
    step("mrst", 0, 0, 1, 1, 1, 1);
    step("mrst", 0, 0, 1, 1, 1, 1);
    step("mrst", 0, 0, 1, 0, 1, 1);
    step("mrst_rst", 1, 0, 0, 0, 0, 0);
    chk("mrst_word",  int'(bus.word_out),   0);
    chk("mrst_valid", int'(bus.word_valid), 0);
    chk("mrst_cnt",   int'(bus.bit_count),  0);
    send_word("mrst_w", 1, 4'b1001, 0);
    chk("mrst_word2", int'(bus.word_out), 4'b1001);

    // Random traffic
    for (int n = 0; n < 600; n++) begin
      step("rand",
           ($urandom_range(0, 99) == 0),
           ($urandom_range(0, 24) == 0),
           1'($urandom),
           1'($urandom),
           ($urandom_range(0, 9) < 7),
           1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
